// File: rtl/tron_pkg.sv
// Shared types and constants for the Tron game controller.
//   game_state_t  : round-flow FSM states (exported on game_state)
//   DIR_*         : one-hot move encoding used by buttons and move commands
//   opposite_dir  : returns the reverse direction (STOP for non-direction input)
package tron_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    ROUND_OVER = 3'd3,
    GAME_OVER  = 3'd4
  } game_state_t;

  localparam logic [3:0] DIR_STOP = 4'b0000;
  localparam logic [3:0] DIR_L    = 4'b0001;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_U    = 4'b0100;
  localparam logic [3:0] DIR_D    = 4'b1000;

  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    logic [3:0] o;
    case (d)
      DIR_L:   o = DIR_R;
      DIR_R:   o = DIR_L;
      DIR_U:   o = DIR_D;
      DIR_D:   o = DIR_U;
      default: o = DIR_STOP;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tron_dir_latch.sv
// Per-player direction register.
//   clock, reset : system clock, async active-low reset (dir <= RST_DIR)
//   btn          : synchronized direction buttons (one-hot move encoding)
//   enable       : accept button presses this cycle
//   load_init    : reload init direction (has priority over enable)
//   init         : round-start direction
//   dir          : current latched direction
// A press is taken only if exactly one button is down and it is neither the
// current direction nor its reverse (a Tron cycle cannot turn back on itself).
module tron_dir_latch
  import tron_pkg::*;
#(
  parameter logic [3:0] RST_DIR = DIR_R
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       enable,
  input  logic       load_init,
  input  logic [3:0] init,
  output logic [3:0] dir
);

  logic accept;

  always_comb begin
    accept = $onehot(btn) && (btn != opposite_dir(dir)) && (btn != dir);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir <= RST_DIR;
    end else if (load_init) begin
      dir <= init;
    end else if (enable && accept) begin
      dir <= btn;
    end
  end

endmodule

// File: rtl/tron_game_ctrl.sv
// Game-flow controller for the two-player Tron datapath.
//   clock, reset         : system clock, async active-low reset
//   frame_end            : 1-cycle end-of-frame pulse; all frame counters step on it
//   start_btn            : start request (rising edge)
//   p1_btn, p2_btn       : direction buttons
//   p1_crash, p2_crash   : head collision flags, sampled on frame_end in PLAY
//   dflt                 : load default start positions (IDLE/COUNTDOWN)
//   p1_info, p2_info     : per-frame move command, valid in the frame_end cycle
//   game_state           : current FSM state
//   countdown            : digit 3..1 during COUNTDOWN, else 0
//   p1_score, p2_score   : rounds won, saturating at WIN_SCORE
//   winner               : 00 none, 01 p1, 10 p2, 11 draw (last round)
module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int unsigned MOVE_DIV     = 2,
  parameter int unsigned CD_FRAMES    = 60,
  parameter int unsigned ROUND_FRAMES = 120,
  parameter int unsigned WIN_SCORE    = 5,
  parameter logic [3:0]  P1_INIT_DIR  = 4'b0010,
  parameter logic [3:0]  P2_INIT_DIR  = 4'b0001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       start_btn,
  input  logic [3:0] p1_btn,
  input  logic [3:0] p2_btn,
  input  logic       p1_crash,
  input  logic       p2_crash,
  output logic       dflt,
  output logic [3:0] p1_info,
  output logic [3:0] p2_info,
  output logic [2:0] game_state,
  output logic [1:0] countdown,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner
);

  localparam int unsigned CNT_MAX = (3 * CD_FRAMES > ROUND_FRAMES) ? 3 * CD_FRAMES : ROUND_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned MW      = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] CD_LAST   = CW'(CD_FRAMES - 1);
  localparam logic [CW-1:0] RF_LAST   = CW'(ROUND_FRAMES - 1);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  game_state_t   state;
  logic [CW-1:0] cnt;
  logic [MW-1:0] move_cnt;
  logic          start_prev;
  logic          start_edge, move_tick, any_crash, game_won, load_dirs, dir_en;
  logic [3:0]    p1_dir, p2_dir;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? s : s + 4'd1;
  endfunction

  always_comb begin
    start_edge = start_btn && !start_prev;
    any_crash  = p1_crash || p2_crash;
    game_won   = (p1_score == WIN) || (p2_score == WIN);
    move_tick  = (state == PLAY) && frame_end && (move_cnt == MOVE_LAST);
    dir_en     = (state == COUNTDOWN) || (state == PLAY);
    // Directions reload on every entry into COUNTDOWN.
    load_dirs  = (((state == IDLE) || (state == GAME_OVER)) && start_edge) ||
                 ((state == ROUND_OVER) && frame_end && (cnt == RF_LAST) && !game_won);
    // A crash on the move frame suppresses the move so the crashed head stays put.
    p1_info    = (move_tick && !any_crash) ? p1_dir : DIR_STOP;
    p2_info    = (move_tick && !any_crash) ? p2_dir : DIR_STOP;
    game_state = state;
  end

  tron_dir_latch #(.RST_DIR(P1_INIT_DIR)) u_p1_dir (
    .clock(clock), .reset(reset), .btn(p1_btn), .enable(dir_en),
    .load_init(load_dirs), .init(P1_INIT_DIR), .dir(p1_dir)
  );

  tron_dir_latch #(.RST_DIR(P2_INIT_DIR)) u_p2_dir (
    .clock(clock), .reset(reset), .btn(p2_btn), .enable(dir_en),
    .load_init(load_dirs), .init(P2_INIT_DIR), .dir(p2_dir)
  );

  // cnt counts frames within one countdown digit (or within ROUND_OVER);
  // the digit register steps down each time cnt wraps, giving 3*CD_FRAMES total.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dflt       <= 1'b1;
      countdown  <= 2'd0;
      cnt        <= '0;
      move_cnt   <= '0;
      p1_score   <= '0;
      p2_score   <= '0;
      winner     <= '0;
      start_prev <= 1'b0;
    end else begin
      start_prev <= start_btn;
      unique case (state)
        IDLE, GAME_OVER: begin
          if (start_edge) begin
            state     <= COUNTDOWN;
            dflt      <= 1'b1;
            countdown <= 2'd3;
            cnt       <= '0;
            p1_score  <= '0;
            p2_score  <= '0;
            winner    <= '0;
          end
        end
        COUNTDOWN: begin
          if (frame_end) begin
            if (cnt == CD_LAST) begin
              cnt <= '0;
              if (countdown == 2'd1) begin
                state     <= PLAY;
                dflt      <= 1'b0;
                countdown <= 2'd0;
                move_cnt  <= '0;
              end else begin
                countdown <= countdown - 2'd1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        PLAY: begin
          if (frame_end) begin
            move_cnt <= move_tick ? '0 : move_cnt + MW'(1);
            if (any_crash) begin
              state <= ROUND_OVER;
              cnt   <= '0;
              if (p1_crash && p2_crash) begin
                winner <= 2'b11;
              end else if (p1_crash) begin
                winner   <= 2'b10;
                p2_score <= sat_inc(p2_score);
              end else begin
                winner   <= 2'b01;
                p1_score <= sat_inc(p1_score);
              end
            end
          end
        end
        ROUND_OVER: begin
          if (frame_end) begin
            if (cnt == RF_LAST) begin
              cnt <= '0;
              if (game_won) begin
                state <= GAME_OVER;
              end else begin
                state     <= COUNTDOWN;
                dflt      <= 1'b1;
                countdown <= 2'd3;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
